npu_neuron_mac: RTL and testbench
=================================

Name: npu_neuron_mac

Overview:
- Arithmetic stage directly downstream of the memory vault.
- Consumes the vault's operand pair each cycle: weight on data_out_a, input/activation on data_out_b.
- Accumulates signed fixed-point products across one neuron's inner cycle, then adds rounding, applies the activation function and saturates.
- Returns the neuron result as calculation_result with a one-cycle activion_valid pulse; the vault uses these for write-back and sequencing.

Parameters:
- NPU_DATA_WIDTH, 16, operand/result width, signed two's complement.
- FRAC_BITS, 8, fractional bits of the Q format (Q7.8 at default).
- ACC_WIDTH, 40, accumulator width; must be >= 2*NPU_DATA_WIDTH+4.

Ports:
- clk  in  1  clock.
- reset_b  in  1  synchronous, active-high reset.
- mac_clear  in  1  start of neuron; zeroes the accumulator (driven from inner_preload).
- mac_valid  in  1  data_a/data_b hold a valid operand pair this cycle.
- mac_last  in  1  qualifies the final pair of the neuron (driven from inner_cycle_match); ignored unless mac_valid=1.
- act_mode  in  2  0=linear, 1=ReLU, 2=leaky ReLU (x>>>3 when negative), 3=reserved, treated as linear.
- data_a  in  NPU_DATA_WIDTH  weight operand.
- data_b  in  NPU_DATA_WIDTH  input operand.
- calculation_result  out  NPU_DATA_WIDTH  activated, saturated neuron output.
- activion_valid  out  1  one-cycle pulse; calculation_result is valid this cycle.
- busy  out  1  high from first accepted pair until activion_valid.
- acc_overflow  out  1  sticky; accumulator saturated during the current neuron.
- protocol_err  out  1  sticky until reset; mac_valid seen while draining.

Behaviour:
Reset and clock
- Single clock domain. Reset is synchronous active-high on reset_b.
- Reset clears all outputs to 0, FSM to IDLE and every pipeline valid bit.
- Reset mid-neuron discards the partial sum; no activion_valid is produced.

Pipeline
- S1 registers the product data_a*data_b as signed 2*NPU_DATA_WIDTH bits, together with valid and last.
- S2 sign-extends the product to ACC_WIDTH and adds it into acc with saturation:
  - on positive/negative overflow, acc clamps to max/min and acc_overflow is set.
- S3 runs only after the last product has been accumulated:
  - r = (acc + 2^(FRAC_BITS-1)) >>> FRAC_BITS (round half up, arithmetic shift);
  - apply the activation selected by act_mode;
  - saturate to [-2^(NPU_DATA_WIDTH-1), 2^(NPU_DATA_WIDTH-1)-1];
  - register the result.
- Latency: pair accepted with mac_last at cycle T -> activion_valid at T+3.
- Throughput: one pair per cycle.

FSM
- States: IDLE, ACCUM, DRAIN, RESULT.
- IDLE -> ACCUM on the first mac_valid.
- ACCUM -> DRAIN on mac_valid & mac_last.
- DRAIN waits until the S2 accumulate of the last product completes, then -> RESULT.
- RESULT drives activion_valid=1 for exactly one cycle, then -> IDLE. busy drops in the same cycle.

Clear and accumulator rules
- mac_clear zeroes acc and acc_overflow.
- mac_clear asserted together with mac_valid: clear first, then that pair becomes the first term.
- mac_clear while in DRAIN/RESULT is ignored for the in-flight result and takes effect on the next neuron.
- mac_last with mac_valid on the very first pair gives a one-term neuron (legal).
- act_mode is sampled when the last pair is accepted; later changes do not affect the in-flight result.

Protocol errors and holds
- mac_valid during DRAIN or RESULT: the pair is dropped and protocol_err is set.
- Neuron with all-zero operands yields 0.
- calculation_result holds its value until the next activion_valid.

Decomposition:
- Shared package/include npu_params: NPU_DATA_WIDTH, FRAC_BITS, ACC_WIDTH, act_mode encodings (ACT_LINEAR, ACT_RELU, ACT_LEAKY), FSM state encodings.
- One sub-module: npu_act_sat, combinational round + activation + saturate, instantiated in S3; reusable by future layer-output paths.

Test Plan:
1. Single neuron, 3 terms. Pairs (0x0180,0x0200), (0x0100,0x0100), (0xFF00,0x0080), mac_last on the third, act_mode=0.
   -> activation_valid 3 cycles after the third pair; result 0x0380 (3.0+1.0-0.5).
2. ReLU clamp. One-term neuron (0xFE00,0x0100), act_mode=1 -> result 0x0000.
   Same stimulus with act_mode=2 -> result 0xFFC0 (-2>>>3 = -0.25).
3. Saturation. Ten pairs (0x7F00,0x7F00) -> result 0x7FFF.
   Ten pairs (0x8000,0x7FFF) -> result 0x8000.
4. Rounding. One-term (0x0001,0x0080) -> result 0x0001; (0x0001,0x007F) -> 0x0000.
5. Back-to-back neurons and clear. mac_clear with the first valid of neuron 2, issued the cycle after neuron 1's activation_valid.
   -> neuron 2 result is unaffected by neuron 1's sum.
   Also: mac_valid during DRAIN -> protocol_err=1 and the result is unchanged.
6. Reset mid-operation. Assert reset_b after 2 of 4 pairs.
   -> no activation_valid, all outputs 0 next cycle.
   A fresh one-term neuron (0x0100,0x0100) afterwards -> result 0x0100.

Source files
------------

// File: rtl/npu_neuron_mac_pkg.sv
// Shared widths plus the activation and FSM encodings used by the neuron MAC datapath.
package npu_neuron_mac_pkg;

   localparam int NPU_DATA_WIDTH = 16;
   localparam int FRAC_BITS      = 8;
   localparam int ACC_WIDTH      = 40;

   typedef logic [1:0] act_mode_t;

   localparam act_mode_t ACT_LINEAR = 2'd0;
   localparam act_mode_t ACT_RELU   = 2'd1;
   localparam act_mode_t ACT_LEAKY  = 2'd2;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCUM  = 2'd1;
   localparam logic [1:0] ST_DRAIN  = 2'd2;
   localparam logic [1:0] ST_RESULT = 2'd3;

   function automatic logic is_busy_state(input logic [1:0] st);
      return (st == ST_ACCUM) || (st == ST_DRAIN);
   endfunction

endpackage

// File: rtl/npu_neuron_mac_if.sv
// Operand/result bundle between the memory vault (master) and the neuron MAC (slave).
interface npu_neuron_mac_if
   import npu_neuron_mac_pkg::*;
#(
   parameter int DW = NPU_DATA_WIDTH
);
   logic          mac_clear;
   logic          mac_valid;
   logic          mac_last;
   act_mode_t     act_mode;
   logic [DW-1:0] data_a;
   logic [DW-1:0] data_b;
   logic [DW-1:0] calculation_result;
   logic          activion_valid;
   logic          busy;
   logic          acc_overflow;
   logic          protocol_err;

   modport master (
      output mac_clear, mac_valid, mac_last, act_mode, data_a, data_b,
      input  calculation_result, activion_valid, busy, acc_overflow, protocol_err
   );

   modport slave (
      input  mac_clear, mac_valid, mac_last, act_mode, data_a, data_b,
      output calculation_result, activion_valid, busy, acc_overflow, protocol_err
   );
endinterface

// File: rtl/npu_neuron_mac_act_sat.sv
// Combinational round-half-up, activation and output saturation of an accumulator value.
module npu_act_sat
   import npu_neuron_mac_pkg::*;
#(
   parameter int DW = NPU_DATA_WIDTH,
   parameter int FB = FRAC_BITS,
   parameter int AW = ACC_WIDTH
) (
   input  logic signed [AW-1:0] i_acc,
   input  act_mode_t            i_act_mode,
   output logic signed [DW-1:0] o_result
);
   localparam logic signed [AW:0] HALF    = (AW+1)'(1) << (FB - 1);
   localparam logic signed [AW:0] SAT_MAX = (AW+1)'((1 << (DW - 1)) - 1);
   localparam logic signed [AW:0] SAT_MIN = ~SAT_MAX;

   logic signed [AW:0] w_rounded;
   logic signed [AW:0] w_shifted;
   logic signed [AW:0] w_act;

   // One guard bit so the rounding add cannot wrap at the accumulator maximum.
   assign w_rounded = $signed({i_acc[AW-1], i_acc}) + HALF;
   assign w_shifted = w_rounded >>> FB;

   always_comb begin
      w_act = w_shifted;
      case (i_act_mode)
         ACT_RELU:  if (w_shifted[AW]) w_act = '0;
         ACT_LEAKY: if (w_shifted[AW]) w_act = w_shifted >>> 3;
         default:   w_act = w_shifted;
      endcase
   end

   always_comb begin
      if (w_act > SAT_MAX) begin
         o_result = SAT_MAX[DW-1:0];
      end else if (w_act < SAT_MIN) begin
         o_result = SAT_MIN[DW-1:0];
      end else begin
         o_result = w_act[DW-1:0];
      end
   end

endmodule

// File: rtl/npu_neuron_mac.sv
// Neuron MAC: registered multiply, saturating accumulate, then round/activate/saturate
// into one result pulse per neuron.
module npu_neuron_mac
   import npu_neuron_mac_pkg::*;
#(
   parameter int DW = NPU_DATA_WIDTH,
   parameter int FB = FRAC_BITS,
   parameter int AW = ACC_WIDTH
) (
   input  logic            clk,
   input  logic            reset_b,
   npu_neuron_mac_if.slave bus
);
   localparam int PW = 2 * DW;
   localparam logic signed [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
   localparam logic signed [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};

   logic [1:0]           r_state;
   logic [1:0]           w_state_next;
   logic                 w_open;
   logic                 w_accept;
   logic signed [PW-1:0] w_op_a;
   logic signed [PW-1:0] w_op_b;
   logic signed [PW-1:0] r_s1_prod;
   logic                 r_s1_valid;
   logic                 r_s1_last;
   logic                 r_s1_clear;
   logic                 r_clear_pend;
   logic                 r_s2_done;
   logic signed [AW-1:0] r_acc;
   logic signed [AW-1:0] w_acc_base;
   logic signed [AW-1:0] w_prod_ext;
   logic signed [AW-1:0] w_acc_next;
   logic [AW:0]          w_sum;
   logic                 w_sum_ovf;
   logic                 r_acc_ovf;
   logic                 r_proto_err;
   act_mode_t            r_act_mode;
   logic signed [DW-1:0] r_result;
   logic signed [DW-1:0] w_act_result;

   // Pairs are only taken while a neuron is open; in DRAIN/RESULT they are dropped.
   assign w_open   = (r_state == ST_IDLE) || (r_state == ST_ACCUM);
   assign w_accept = bus.mac_valid && w_open;
   assign w_op_a   = PW'($signed(bus.data_a));
   assign w_op_b   = PW'($signed(bus.data_b));

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:  if (w_accept) w_state_next = bus.mac_last ? ST_DRAIN : ST_ACCUM;
         ST_ACCUM: if (w_accept && bus.mac_last) w_state_next = ST_DRAIN;
         ST_DRAIN: if (r_s2_done) w_state_next = ST_RESULT;
         default:  w_state_next = ST_IDLE;
      endcase
   end

   // A clear travels with S1 so it lands in S2 just ahead of its own pair's product.
   assign w_acc_base = r_s1_clear ? '0 : r_acc;
   assign w_prod_ext = {{(AW-PW){r_s1_prod[PW-1]}}, r_s1_prod};
   assign w_sum      = {w_acc_base[AW-1], w_acc_base} + {w_prod_ext[AW-1], w_prod_ext};
   assign w_sum_ovf  = w_sum[AW] ^ w_sum[AW-1];

   always_comb begin
      w_acc_next = w_acc_base;
      if (r_s1_valid) begin
         if (w_sum_ovf) begin
            w_acc_next = w_sum[AW] ? ACC_MIN : ACC_MAX;
         end else begin
            w_acc_next = w_sum[AW-1:0];
         end
      end
   end

   npu_act_sat #(
      .DW (DW),
      .FB (FB),
      .AW (AW)
   ) u_act_sat (
      .i_acc      (r_acc),
      .i_act_mode (r_act_mode),
      .o_result   (w_act_result)
   );

   always_ff @(posedge clk) begin
      if (reset_b) begin
         r_state      <= ST_IDLE;
         r_s1_prod    <= '0;
         r_s1_valid   <= 1'b0;
         r_s1_last    <= 1'b0;
         r_s1_clear   <= 1'b0;
         r_clear_pend <= 1'b0;
         r_s2_done    <= 1'b0;
         r_acc        <= '0;
         r_acc_ovf    <= 1'b0;
         r_proto_err  <= 1'b0;
         r_act_mode   <= ACT_LINEAR;
         r_result     <= '0;
      end else begin
         r_state    <= w_state_next;
         r_s1_prod  <= w_op_a * w_op_b;
         r_s1_valid <= w_accept;
         r_s1_last  <= w_accept && bus.mac_last;
         r_s1_clear <= w_open && (bus.mac_clear || r_clear_pend);

         // A clear seen while a result is in flight is held over for the next neuron.
         if (w_open) begin
            r_clear_pend <= 1'b0;
         end else if (bus.mac_clear) begin
            r_clear_pend <= 1'b1;
         end

         r_acc     <= w_acc_next;
         r_acc_ovf <= (r_acc_ovf && !r_s1_clear) || (r_s1_valid && w_sum_ovf);
         r_s2_done <= r_s1_valid && r_s1_last;

         if (w_accept && bus.mac_last) begin
            r_act_mode <= bus.act_mode;
         end
         if (r_s2_done) begin
            r_result <= w_act_result;
         end
         if (bus.mac_valid && !w_open) begin
            r_proto_err <= 1'b1;
         end
      end
   end

   assign bus.calculation_result = r_result;
   assign bus.activion_valid     = (r_state == ST_RESULT);
   assign bus.busy               = is_busy_state(r_state);
   assign bus.acc_overflow       = r_acc_ovf;
   assign bus.protocol_err       = r_proto_err;

endmodule

// File: tb/tb_npu_neuron_mac.sv
// Randomised and directed bench for npu_neuron_mac against a cycle-tagged arithmetic model.
module tb_npu_neuron_mac;
   localparam int     BIG     = 32'h7fff_ffff;
   localparam longint ACC_MAX = (longint'(1) <<< 39) - 1;
   localparam longint ACC_MIN = -(longint'(1) <<< 39);

   typedef struct {
      int          cyc;
      logic [15:0] res;
      logic        ovf;
   } exp_t;

   logic clk     = 1'b0;
   logic reset_b = 1'b1;
   always #5 clk = ~clk;

   npu_neuron_mac_if #(.DW(16)) bus_if ();

   npu_neuron_mac u_dut (
      .clk     (clk),
      .reset_b (reset_b),
      .bus     (bus_if)
   );

   int          cyc = 0;
   int          n_checks = 0;
   int          n_err = 0;
   bit          checking = 1'b0;
   int          rst_cyc = -1;
   int          busy_lo = BIG;
   int          busy_hi = -1;
   int          exp_proto_cyc = BIG;
   logic [15:0] exp_result = '0;
   logic        cmp_exp_valid;
   exp_t        exp_q[$];
   longint      m_acc = 0;
   logic        m_ovf = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
      end
   endtask

   // Spec-level result: round half up, activation, clamp to Q7.8 range.
   function automatic logic [15:0] act_sat_model(input longint acc, input logic [1:0] mode);
      longint r;
      r = (acc + 128) >>> 8;
      if (mode == 2'd1 && r < 0) r = 0;
      if (mode == 2'd2 && r < 0) r = r >>> 3;
      if (r > 32767) r = 32767;
      if (r < -32768) r = -32768;
      return r[15:0];
   endfunction

   function automatic logic [15:0] rand_op();
      if ($urandom_range(0, 3) == 0) return 16'($urandom);
      return 16'($urandom_range(0, 2047)) - 16'd1024;
   endfunction

   always @(negedge clk) begin
      if (checking) begin
         if (cyc == rst_cyc) begin
            exp_result    = '0;
            exp_proto_cyc = BIG;
            exp_q.delete();
            check("ovf_after_reset", bus_if.acc_overflow, 0);
         end
         cmp_exp_valid = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
         check("activion_valid", bus_if.activion_valid, cmp_exp_valid);
         if (cmp_exp_valid) begin
            exp_result = exp_q[0].res;
            check("acc_overflow", bus_if.acc_overflow, exp_q[0].ovf);
            $display("neuron cyc=%0d result=%h expect=%h ovf=%0b", cyc,
                     bus_if.calculation_result, exp_q[0].res, bus_if.acc_overflow);
            void'(exp_q.pop_front());
         end
         check("calculation_result", bus_if.calculation_result, exp_result);
         check("busy", bus_if.busy, (cyc >= busy_lo) && (cyc <= busy_hi));
         check("protocol_err", bus_if.protocol_err, cyc >= exp_proto_cyc);
      end
   end

   task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                        input logic last, input logic clr, input logic [1:0] mode);
      @(posedge clk);
      #1;
      bus_if.mac_valid = v;
      bus_if.data_a    = a;
      bus_if.data_b    = b;
      bus_if.mac_last  = last;
      bus_if.mac_clear = clr;
      bus_if.act_mode  = mode;
   endtask

   task automatic idle();
      drive(1'b0, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0, 2'($urandom));
   endtask

   task automatic send_pair(input logic [15:0] a, input logic [15:0] b, input bit first,
                            input bit last, input bit clr, input logic [1:0] mode,
                            input bit lit_en, input logic [15:0] lit);
      longint      s;
      logic [15:0] r;
      exp_t        e;
      drive(1'b1, a, b, last, clr, mode);
      if (first) begin
         busy_lo = cyc + 1;
         busy_hi = BIG;
         m_acc   = 0;
         m_ovf   = 1'b0;
      end
      s = m_acc + longint'($signed(a)) * longint'($signed(b));
      if (s > ACC_MAX) begin
         s = ACC_MAX;
         m_ovf = 1'b1;
      end else if (s < ACC_MIN) begin
         s = ACC_MIN;
         m_ovf = 1'b1;
      end
      m_acc = s;
      if (last) begin
         r     = act_sat_model(m_acc, mode);
         e.cyc = cyc + 3;
         e.res = r;
         e.ovf = m_ovf;
         exp_q.push_back(e);
         busy_hi = cyc + 2;
         if (lit_en) check("model_literal", r, lit);
      end
   endtask

   // Three cycles after the last pair: DRAIN, DRAIN, RESULT.
   task automatic post_last(input bit clr_drain, input bit bad_valid);
      if (bad_valid) begin
         drive(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0, 2'($urandom));
         if (exp_proto_cyc > cyc + 1) exp_proto_cyc = cyc + 1;
      end else begin
         drive(1'b0, 16'($urandom), 16'($urandom), 1'($urandom), clr_drain, 2'($urandom));
      end
      idle();
      idle();
   endtask

   task automatic rep_neuron(input int n, input logic [15:0] a, input logic [15:0] b,
                             input logic [1:0] mode, input logic [15:0] lit);
      for (int i = 0; i < n; i++) begin
         send_pair(a, b, i == 0, i == n - 1, i == 0, (i == n - 1) ? mode : 2'($urandom), 1'b1, lit);
      end
      post_last(1'b0, 1'b0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      reset_b          = 1'b1;
      bus_if.mac_valid = 1'b0;
      bus_if.mac_clear = 1'b0;
      rst_cyc          = cyc + 1;
      busy_hi          = cyc;
      @(posedge clk);
      #1;
      reset_b  = 1'b0;
      checking = 1'b1;
   endtask

   initial begin
      #400_000;
      $display("FAIL watchdog timeout cyc=%0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      bit prev_drain_clr;
      int n;
      bus_if.mac_valid = 1'b0;
      bus_if.mac_clear = 1'b0;
      bus_if.mac_last  = 1'b0;
      bus_if.act_mode  = 2'd0;
      bus_if.data_a    = '0;
      bus_if.data_b    = '0;
      do_reset();
      idle();

      // 3-term linear neuron: 3.0 + 1.0 - 0.5
      send_pair(16'h0180, 16'h0200, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0, '0);
      send_pair(16'h0100, 16'h0100, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, '0);
      send_pair(16'hFF00, 16'h0080, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 16'h0380);
      post_last(1'b0, 1'b0);

      rep_neuron(1, 16'hFE00, 16'h0100, 2'd1, 16'h0000);
      rep_neuron(1, 16'hFE00, 16'h0100, 2'd2, 16'hFFC0);
      rep_neuron(10, 16'h7F00, 16'h7F00, 2'd0, 16'h7FFF);
      rep_neuron(10, 16'h8000, 16'h7FFF, 2'd0, 16'h8000);
      rep_neuron(520, 16'h8000, 16'h8000, 2'd0, 16'h7FFF);
      check("model_ovf_literal", m_ovf, 1);
      rep_neuron(1, 16'h0001, 16'h0080, 2'd0, 16'h0001);
      rep_neuron(1, 16'h0001, 16'h007F, 2'd0, 16'h0000);
      rep_neuron(3, 16'h0000, 16'h0000, 2'd2, 16'h0000);

      prev_drain_clr = 1'b0;
      for (int k = 0; k < 40; k++) begin
         n = $urandom_range(1, 12);
         repeat ($urandom_range(0, 2)) idle();
         for (int i = 0; i < n; i++) begin
            if (i > 0) repeat ($urandom_range(0, 2)) idle();
            send_pair(rand_op(), rand_op(), i == 0, i == n - 1, (i == 0) && !prev_drain_clr,
                      2'($urandom), 1'b0, '0);
         end
         prev_drain_clr = 1'($urandom);
         post_last(prev_drain_clr, 1'b0);
      end
      if (prev_drain_clr) begin
         rep_neuron(1, 16'h0100, 16'h0100, 2'd0, 16'h0100);
      end

      // Back-to-back neurons, then a pair pushed during DRAIN.
      send_pair(16'h0400, 16'h0400, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, '0);
      send_pair(16'h0100, 16'h0200, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 16'h1200);
      post_last(1'b0, 1'b0);
      send_pair(16'h0100, 16'h0300, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 16'h0300);
      post_last(1'b0, 1'b1);
      idle();
      idle();

      // Reset after 2 of 4 pairs, then a fresh one-term neuron.
      send_pair(16'h0500, 16'h0500, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, '0);
      send_pair(16'h0500, 16'h0500, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, '0);
      do_reset();
      repeat (4) idle();
      rep_neuron(1, 16'h0100, 16'h0100, 2'd0, 16'h0100);
      repeat (4) idle();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
